// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int                    INST_WIDTH       = 32;
  localparam logic [31:0]           DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INST_WIDTH-1:0] NOP_INST         = 32'h0000_0013;
  localparam int                    FETCH_BUF_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  // One buffered fetch: the word and the address it came from.
  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [31:0]           pc;
  } fetch_entry_t;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular instruction buffer with push, pop and single-cycle flush.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; flush wins over push/pop
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    do_push  = push & ~flush;
    do_pop   = pop & ~empty & ~flush;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Buffer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues in-order memory requests, buffers returned
// words, and discards in-flight responses after a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = FETCH_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  system_stall,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  imem_req,
  output logic [31:0]           imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [INST_WIDTH-1:0] instruction,
  output logic [31:0]           instr_pc,
  output logic                  instr_valid
);
  localparam int FCW = $clog2(BUF_DEPTH + 1);
  localparam int CW  = FCW + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;     // granted, response not yet seen
  logic [CW-1:0] disc_q, disc_d;   // responses still to be thrown away
  logic [CW-1:0] occ;
  logic          fire, rv_run, rv_drop;

  logic           fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_count;
  fetch_entry_t   head_entry, push_entry;
  logic [31:0]    resp_pc;

  // Responses are in order, so the oldest outstanding fetch sits out_q
  // words behind the next request address.
  assign resp_pc    = pc_q - (32'(out_q) << 2);
  assign push_entry = '{inst: imem_rdata, pc: resp_pc};
  assign occ        = CW'(fifo_count) + out_q;

  assign imem_addr   = pc_q;
  assign instr_valid = ~fifo_empty;
  assign instruction = fifo_empty ? NOP_INST : head_entry.inst;
  assign instr_pc    = fifo_empty ? pc_q : head_entry.pc;
  assign fifo_pop    = instr_valid & ~system_stall & ~redirect_valid;

  // Next-state, request generation and fetch accounting
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    disc_d     = disc_q;
    imem_req   = 1'b0;
    fifo_flush = 1'b0;
    rv_run     = 1'b0;
    rv_drop    = 1'b0;
    case (state_q)
      IDLE:  state_d = RUN;
      RUN: begin
        imem_req = (occ < CW'(BUF_DEPTH)) && !redirect_valid;
        rv_run   = imem_rvalid && (out_q != '0);
      end
      FLUSH: rv_drop = imem_rvalid && (disc_q != '0);
      default: state_d = IDLE;
    endcase
    fire      = imem_req & imem_gnt;
    if (fire) pc_d = pc_q + 32'd4;
    out_d     = out_q + CW'(fire) - CW'(rv_run);
    fifo_push = rv_run;
    if (rv_drop) disc_d = disc_q - CW'(1);
    if (state_q == FLUSH && disc_d == '0) state_d = RUN;
    // A redirect turns everything still in flight into discards
    if (redirect_valid) begin
      fifo_flush = 1'b1;
      fifo_push  = 1'b0;
      pc_d       = align_word(redirect_pc);
      disc_d     = disc_d + out_d;
      out_d      = '0;
      state_d    = (disc_d != '0) ? FLUSH : RUN;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // PC and in-flight counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      disc_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      disc_q <= disc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_buf (
    .clk   (clk),
    .rst   (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Occupancy accounting must make a push into a full buffer unreachable
  always_ff @(posedge clk) begin
    if (!reset) assert (!(fifo_push && fifo_full && !fifo_pop));
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  system_stall = 1'b0;
  logic                  redirect_valid = 1'b0;
  logic [31:0]           redirect_pc = '0;
  logic                  imem_req;
  logic [31:0]           imem_addr;
  logic                  imem_gnt = 1'b0;
  logic                  imem_rvalid = 1'b0;
  logic [INST_WIDTH-1:0] imem_rdata = '0;
  logic [INST_WIDTH-1:0] instruction;
  logic [31:0]           instr_pc;
  logic                  instr_valid;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .system_stall(system_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting at %0t", nm, $time);
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- memory model + delivery scoreboard ----------------
  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } mreq_t;

  mreq_t       pend[$];
  int          cyc = 0;
  int          lat = 1;
  int          gnt_pct = 100;
  logic [31:0] exp_pc = RST_PC;
  int          consumed = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;

  always begin
    @(negedge clk);
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (!reset && pend.size() > 0 && pend[0].rdy <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memword(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #3;
    if (reset) begin
      pend.delete();
      exp_pc    = RST_PC;
      prev_hold = 1'b0;
    end else begin
      if (imem_rvalid) void'(pend.pop_front());
      if (prev_hold && !redirect_valid) begin
        chk("req_hold", 32'(imem_req), 32'd1);
        chk("addr_hold", imem_addr, prev_addr);
      end
      if (redirect_valid) begin
        chk("req_withdrawn", 32'(imem_req), 32'd0);
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (instr_valid && !system_stall) begin
        chk("deliver_pc", instr_pc, exp_pc);
        chk("deliver_inst", instruction, memword(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (!instr_valid) chk("empty_nop", instruction, NOP_INST);
      if (imem_req && imem_gnt) begin
        pend.push_back('{imem_addr, cyc + lat});
        chk("occupancy", 32'(pend.size() <= DEPTH), 32'd1);
      end
      prev_hold = imem_req && !imem_gnt;
      prev_addr = imem_addr;
    end
    cyc++;
  end

  // ---------------- directed + table + random stimulus ----------------
  typedef struct {
    logic [31:0] tgt;
    logic [31:0] exp_addr;
    int          lat;
    int          gnt;
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    logic [31:0] held_pc, held_inst;
    int drops, seen;
    logic ok;

    vecs[0] = '{32'h0000_0203, 32'h0000_0200, 1, 100};
    vecs[1] = '{32'h0000_0100, 32'h0000_0100, 2, 100};
    vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 1, 60};
    vecs[3] = '{32'h0000_0001, 32'h0000_0000, 3, 80};
    vecs[4] = '{32'h8000_0007, 32'h8000_0004, 2, 50};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_inst", instruction, NOP_INST);
    chk("rst_pc", instr_pc, RST_PC);
    chk("rst_valid", 32'(instr_valid), 32'd0);

    // first fetches after release
    @(negedge clk); reset = 1'b0; #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    @(negedge clk); #1;
    chk("run_req", 32'(imem_req), 32'd1);
    chk("run_addr", imem_addr, RST_PC);
    chk("early_valid1", 32'(instr_valid), 32'd0);
    @(negedge clk); #1;
    chk("early_valid2", 32'(instr_valid), 32'd0);
    @(negedge clk); #1;
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_pc", instr_pc, RST_PC);
    seen = 0;
    for (int c = 0; c < 12 && seen < 2; c++) begin
      @(negedge clk); #1;
      if (instr_valid) begin
        seen++;
        chk("seq_pc", instr_pc, RST_PC + 32'(4 * seen));
      end
    end
    if (seen < 2) timeout("seq_pc");

    // hold the decoder for 5 cycles
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (instr_valid) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("stall_start");
    system_stall = 1'b1;
    held_pc = instr_pc;
    held_inst = instruction;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); #1;
      chk("stall_pc", instr_pc, held_pc);
      chk("stall_inst", instruction, held_inst);
      if (i >= 3) chk("stall_req", 32'(imem_req), 32'd0);
    end
    @(negedge clk); system_stall = 1'b0;
    @(negedge clk); #1;
    chk("post_stall_valid", 32'(instr_valid), 32'd1);
    chk("post_stall_pc", instr_pc, held_pc + 32'd4);

    // redirect with two fetches outstanding
    lat = 4;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (pend.size() == 2 && !imem_rvalid) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("two_outstanding");
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1 chk("redir_req", 32'(imem_req), 32'd0);
    @(negedge clk); redirect_valid = 1'b0;
    drops = 0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (imem_req) begin ok = 1'b1; break; end
      if (imem_rvalid) drops++;
      chk("flush_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
    end
    if (!ok) timeout("flush_exit");
    chk("flush_drops", 32'(drops), 32'd2);
    chk("flush_addr", imem_addr, 32'h0000_0100);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (instr_valid) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (!ok) timeout("redir_first");
    chk("redir_first_pc", instr_pc, 32'h0000_0100);

    // redirect coincident with a response and a grant
    lat = 2;
    gnt_pct = 100;
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (imem_rvalid && imem_gnt) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("coincident");
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    #1 chk("coinc_req", 32'(imem_req), 32'd0);
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("coinc_valid", 32'(instr_valid), 32'd0);
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (instr_valid) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (!ok) timeout("coinc_first");
    chk("coinc_first_pc", instr_pc, 32'h0000_0300);

    // table of redirect targets
    for (int v = 0; v < 5; v++) begin
      lat = vecs[v].lat;
      gnt_pct = vecs[v].gnt;
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = vecs[v].tgt;
      @(negedge clk); redirect_valid = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 30; c++) begin
        #1;
        if (imem_req) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (!ok) timeout("tbl_req");
      chk("tbl_addr", imem_addr, vecs[v].exp_addr);
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (instr_valid) begin ok = 1'b1; break; end
        @(negedge clk); #1;
      end
      if (!ok) timeout("tbl_valid");
      chk("tbl_first_pc", instr_pc, vecs[v].exp_addr);
    end

    // asynchronous reset with one fetch outstanding
    lat = 3;
    gnt_pct = 100;
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (pend.size() == 1) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("one_outstanding");
    reset = 1'b1;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_addr", imem_addr, RST_PC);
    chk("arst_inst", instruction, NOP_INST);
    chk("arst_pc", instr_pc, RST_PC);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (instr_valid) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("arst_resume");
    chk("arst_resume_pc", instr_pc, RST_PC);

    // randomized traffic against the delivery scoreboard
    consumed = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (c % 100 == 0) begin
        lat = $urandom_range(4, 1);
        gnt_pct = $urandom_range(100, 30);
      end
      system_stall   = ($urandom_range(99) < 30);
      redirect_valid = ($urandom_range(99) < 4);
      redirect_pc    = $urandom;
      if ($urandom_range(499) == 0) begin
        #1 reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
      end
    end
    @(negedge clk);
    system_stall = 1'b0;
    redirect_valid = 1'b0;
    chk("progress", 32'(consumed > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
